// File: rtl/mlp_layer_sequencer.sv
// Layer sequencer for one INT8 fully-connected layer: clear -> N chunk MACs -> activation -> write, per neuron.
// All outputs come from flops. Their next values are decoded from the next FSM state.
module mlp_layer_sequencer #(
   parameter int MAX_NEURONS = 64,
   parameter int MAX_CHUNKS  = 16,
   parameter int RD_LATENCY  = 1,
   parameter int TIMEOUT     = 255,
   localparam int NW = $clog2(MAX_NEURONS),
   localparam int CW = $clog2(MAX_CHUNKS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [NW:0]       i_cfg_num_neurons,
   input  logic [CW:0]       i_cfg_num_chunks,
   input  logic [1:0]        i_cfg_act_type,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error,
   output logic              o_buf_rd_en,
   output logic [CW-1:0]     o_buf_chunk,
   output logic [NW-1:0]     o_buf_neuron,
   output logic              o_mac_clear,
   output logic              o_mac_enable,
   input  logic              i_mac_valid,
   output logic              o_activation_enable,
   output logic [1:0]        o_activation_type,
   input  logic              i_result_valid,
   input  logic signed [7:0] i_result_in,
   output logic              o_out_wr_en,
   output logic [NW-1:0]     o_out_addr,
   output logic signed [7:0] o_out_data
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_FETCH, S_WAIT_RD, S_MAC,
      S_WAIT_MAC, S_ACT, S_WAIT_ACT, S_WRITE, S_DONE
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [NW-1:0]   r_neuron, w_neuron_nxt;
   logic [CW-1:0]   r_chunk, w_chunk_nxt;
   logic [NW:0]     r_num_neurons, w_num_neurons_nxt;
   logic [CW:0]     r_num_chunks, w_num_chunks_nxt;
   logic [1:0]      r_act_type, w_act_type_nxt;
   logic [TW-1:0]   r_wait, w_wait_nxt;
   logic [RW-1:0]   r_rd_cnt, w_rd_cnt_nxt;
   logic            w_accept, w_timeout;
   logic [NW:0]     w_cfg_neurons;
   logic [CW:0]     w_cfg_chunks;
   logic [NW:0]     w_last_neuron;
   logic [CW:0]     w_last_chunk;

   logic            w_busy, w_done, w_error, w_buf_rd_en, w_mac_clear, w_mac_enable;
   logic            w_act_enable, w_out_wr_en;
   logic signed [7:0] w_out_data;

   // Out-of-range configurations are clamped so the index counters always hit their terminal value.
   always_comb begin
      w_cfg_neurons = i_cfg_num_neurons;
      if (i_cfg_num_neurons == '0)
         w_cfg_neurons = (NW+1)'(1);
      else if (i_cfg_num_neurons > (NW+1)'(MAX_NEURONS))
         w_cfg_neurons = (NW+1)'(MAX_NEURONS);
      w_cfg_chunks = i_cfg_num_chunks;
      if (i_cfg_num_chunks == '0)
         w_cfg_chunks = (CW+1)'(1);
      else if (i_cfg_num_chunks > (CW+1)'(MAX_CHUNKS))
         w_cfg_chunks = (CW+1)'(MAX_CHUNKS);
      w_last_neuron = r_num_neurons - (NW+1)'(1);
      w_last_chunk  = r_num_chunks - (CW+1)'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state             <= S_IDLE;
         r_neuron            <= '0;
         r_chunk             <= '0;
         r_num_neurons       <= '0;
         r_num_chunks        <= '0;
         r_act_type          <= '0;
         r_wait              <= '0;
         r_rd_cnt            <= '0;
         o_busy              <= 1'b0;
         o_done              <= 1'b0;
         o_error             <= 1'b0;
         o_buf_rd_en         <= 1'b0;
         o_buf_chunk         <= '0;
         o_buf_neuron        <= '0;
         o_mac_clear         <= 1'b0;
         o_mac_enable        <= 1'b0;
         o_activation_enable <= 1'b0;
         o_activation_type   <= '0;
         o_out_wr_en         <= 1'b0;
         o_out_addr          <= '0;
         o_out_data          <= '0;
      end else begin
         r_state             <= w_state_nxt;
         r_neuron            <= w_neuron_nxt;
         r_chunk             <= w_chunk_nxt;
         r_num_neurons       <= w_num_neurons_nxt;
         r_num_chunks        <= w_num_chunks_nxt;
         r_act_type          <= w_act_type_nxt;
         r_wait              <= w_wait_nxt;
         r_rd_cnt            <= w_rd_cnt_nxt;
         o_busy              <= w_busy;
         o_done              <= w_done;
         o_error             <= w_error;
         o_buf_rd_en         <= w_buf_rd_en;
         o_buf_chunk         <= w_chunk_nxt;
         o_buf_neuron        <= w_neuron_nxt;
         o_mac_clear         <= w_mac_clear;
         o_mac_enable        <= w_mac_enable;
         o_activation_enable <= w_act_enable;
         o_activation_type   <= w_act_type_nxt;
         o_out_wr_en         <= w_out_wr_en;
         o_out_addr          <= w_neuron_nxt;
         o_out_data          <= w_out_data;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_neuron_nxt      = r_neuron;
      w_chunk_nxt       = r_chunk;
      w_num_neurons_nxt = r_num_neurons;
      w_num_chunks_nxt  = r_num_chunks;
      w_act_type_nxt    = r_act_type;
      w_wait_nxt        = r_wait;
      w_rd_cnt_nxt      = r_rd_cnt;
      w_accept          = 1'b0;
      w_timeout         = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_accept          = 1'b1;
               w_num_neurons_nxt = w_cfg_neurons;
               w_num_chunks_nxt  = w_cfg_chunks;
               w_act_type_nxt    = i_cfg_act_type;
               w_neuron_nxt      = '0;
               w_chunk_nxt       = '0;
               w_state_nxt       = S_CLEAR;
            end
         end
         S_CLEAR: w_state_nxt = S_FETCH;
         S_FETCH: begin
            w_rd_cnt_nxt = '0;
            w_state_nxt  = S_WAIT_RD;
         end
         S_WAIT_RD: begin
            if (r_rd_cnt == RW'(RD_LATENCY - 1))
               w_state_nxt = S_MAC;
            else
               w_rd_cnt_nxt = r_rd_cnt + RW'(1);
         end
         S_MAC: begin
            w_wait_nxt  = '0;
            w_state_nxt = S_WAIT_MAC;
         end
         S_WAIT_MAC: begin
            // A valid arriving on the final wait cycle wins over the timeout.
            if (i_mac_valid) begin
               if ({1'b0, r_chunk} == w_last_chunk) begin
                  w_chunk_nxt = '0;
                  w_state_nxt = S_ACT;
               end else begin
                  w_chunk_nxt = r_chunk + CW'(1);
                  w_state_nxt = S_FETCH;
               end
            end else if (r_wait >= TW'(TIMEOUT - 1)) begin
               w_timeout    = 1'b1;
               w_neuron_nxt = '0;
               w_chunk_nxt  = '0;
               w_state_nxt  = S_IDLE;
            end else begin
               w_wait_nxt = r_wait + TW'(1);
            end
         end
         S_ACT: begin
            w_wait_nxt  = '0;
            w_state_nxt = S_WAIT_ACT;
         end
         S_WAIT_ACT: begin
            if (i_result_valid) begin
               w_state_nxt = S_WRITE;
            end else if (r_wait >= TW'(TIMEOUT - 1)) begin
               w_timeout    = 1'b1;
               w_neuron_nxt = '0;
               w_chunk_nxt  = '0;
               w_state_nxt  = S_IDLE;
            end else begin
               w_wait_nxt = r_wait + TW'(1);
            end
         end
         S_WRITE: begin
            if ({1'b0, r_neuron} == w_last_neuron) begin
               w_state_nxt = S_DONE;
            end else begin
               w_neuron_nxt = r_neuron + NW'(1);
               w_state_nxt  = S_CLEAR;
            end
         end
         S_DONE: begin
            w_neuron_nxt = '0;
            w_state_nxt  = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_done       = 1'b0;
      w_buf_rd_en  = 1'b0;
      w_mac_clear  = 1'b0;
      w_mac_enable = 1'b0;
      w_act_enable = 1'b0;
      w_out_wr_en  = 1'b0;
      w_error      = o_error;
      w_out_data   = o_out_data;
      unique case (w_state_nxt)
         S_CLEAR: w_mac_clear  = 1'b1;
         S_FETCH: w_buf_rd_en  = 1'b1;
         S_MAC:   w_mac_enable = 1'b1;
         S_ACT:   w_act_enable = 1'b1;
         S_WRITE: w_out_wr_en  = 1'b1;
         S_DONE:  w_done       = 1'b1;
         default: ;
      endcase
      w_busy = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      if (w_accept)
         w_error = 1'b0;
      else if (w_timeout)
         w_error = 1'b1;
      if ((r_state == S_WAIT_ACT) && i_result_valid)
         w_out_data = i_result_in;
   end

endmodule
